fbreader: RTL and testbench
===========================

Name: fbreader

Overview:
- PLB master block that scans the framebuffer in raster order with single-beat reads.
- Pushes each pixel, tagged with its line and column, into a downstream FIFO.
- It is the read-side counterpart of the rasterizer's framebuffer writer: same address map, same IPIF master interface, opposite transfer direction.
- Its consumers are the display scan-out and read-back paths.

Parameters:
- LINE_LEN, 9, line index width.
- COL_LEN, 10, column index width.
- NUM_LINES, 480, lines per frame (1..2^LINE_LEN).
- NUM_COLS, 640, columns per line (1..2^COL_LEN).
- FB_BASE, 11'b1001_0000_000, framebuffer base; drives address bits [0:10].
- FBR_FIFO_LEN, 64, output FIFO word width.
- C_MST_AWIDTH, 32, PLB master address width.
- C_MST_DWIDTH, 32, PLB master data width.

Ports:
- PLB_clk  in  1  single clock; all logic on rising edge.
- Bus2IP_Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame scan; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel is pushed.
- fifo_data  out  [0:FBR_FIFO_LEN-1]  [0:8] line, [9:18] col, [19:31] zero, [32:63] pixel.
- fifo_full  in  1  downstream FIFO full.
- fifo_wr_en  out  1  write strobe, one cycle per pixel.
- IP2Bus_MstRd_Req  out  1  read request.
- IP2Bus_MstWr_Req  out  1  tied 0.
- IP2Bus_Mst_Addr  out  [0:C_MST_AWIDTH-1]  {FB_BASE, line, col, 2'b00}.
- IP2Bus_Mst_BE  out  [0:C_MST_DWIDTH/8-1]  all ones.
- IP2Bus_Mst_Lock  out  1  tied 0.
- IP2Bus_Mst_Reset  out  1  registered IPIF master reset.
- Bus2IP_Mst_CmdAck  in  1  command accepted.
- Bus2IP_Mst_Cmplt  in  1  transfer complete.
- Bus2IP_Mst_Error  in  1  transfer error.
- Bus2IP_Mst_Rearbitrate  in  1  unused.
- Bus2IP_Mst_Cmd_Timeout  in  1  treated as an error.
- Bus2IP_MstRd_d  in  [0:C_MST_DWIDTH-1]  read data.
- Bus2IP_MstRd_src_rdy_n  in  1  read data valid, active low.
- IP2Bus_MstWr_d  out  [0:C_MST_DWIDTH-1]  tied 0.
- Bus2IP_MstWr_dst_rdy_n  in  1  unused.

Behaviour:
- Reset:
  - state=IDLE; line=0, col=0.
  - busy, done, fifo_wr_en, IP2Bus_MstRd_Req all 0.
  - IP2Bus_Mst_Reset=1 in the cycle after any cycle with Bus2IP_Reset high.
  - Reset mid-transfer abandons the pixel; no FIFO write occurs.
- States:
  - IDLE: on start go to REQ with line=col=0, busy=1.
  - REQ: IP2Bus_MstRd_Req=1.
    - Error or timeout -> ERR.
    - CmdAck&&Cmplt -> PUSH.
    - CmdAck -> WAIT.
  - WAIT: Req=0.
    - Error or timeout -> ERR.
    - Cmplt -> PUSH.
  - PUSH: hold while fifo_full; when !fifo_full, fifo_wr_en=1 for exactly one cycle, then advance.
  - ERR: IP2Bus_Mst_Reset=1 (registered, lags ERR by one cycle). Stay in ERR while Error is high, then return to REQ for the same line/col (retry).
- Data capture:
  - Pixel register loads Bus2IP_MstRd_d on any REQ/WAIT cycle with src_rdy_n=0.
  - If Cmplt arrives without captured data -> ERR.
- Advance (in the PUSH write cycle):
  - col<NUM_COLS-1: col+1, go to REQ.
  - Otherwise col=0 and line+1, go to REQ.
  - At line=NUM_LINES-1 and col=NUM_COLS-1: go to IDLE, done=1 next cycle, busy=0 with done.
- Latency:
  - start to Req high: 1 cycle.
  - Cmplt to fifo_wr_en, FIFO not full: 1 cycle.
  - fifo_wr_en to next Req: 1 cycle.
- Boundaries:
  - start while busy: ignored.
  - start in the same cycle as done: accepted (IDLE reached).
  - fifo_data is stable while fifo_wr_en is high and during PUSH stalls.
  - Error in the same cycle as CmdAck/Cmplt: Error wins.

Optional Feature:
- FBR_ERR_CNT_EN
- Defined:
  - Adds output err_cnt [0:7].
  - Increments on each entry to ERR, saturating at 255.
  - Cleared to 0 on reset and on accepted start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Bench parameters: NUM_LINES=2, NUM_COLS=3.
- Basic frame: start, responder acks and completes each read in 2 cycles returning addr^32'hA5A5_0000, fifo_full=0 -> 6 pushes in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2). Addresses 0x9000_0000, 0x9000_0004, 0x9000_0008, then line 1 at 0x9000_1000 (line is address bits [11:19]). done pulses once, busy low after.
- Back-pressure: fifo_full=1 for 5 cycles at pixel (0,1) -> fifo_wr_en stays 0 and fifo_data holds; single write when full drops; no new Req during the stall.
- Same-cycle ack: CmdAck, Cmplt and src_rdy_n=0 all in one cycle -> fifo_wr_en exactly 1 cycle later; WAIT never visited.
- Error retry: Error during the read of pixel (1,1) -> IP2Bus_Mst_Reset pulses, Req reissued for 0x9000_1004, pixel pushed once; err_cnt=1 with FBR_ERR_CNT_EN.
- Reset mid-read: Bus2IP_Reset while in WAIT -> Req=0, no push, IP2Bus_Mst_Reset=1 next cycle; the next start restarts at (0,0).
- start while busy: second start at pixel (0,2) -> ignored, frame completes normally with a single done.

Source files
------------

// File: rtl/fbreader.sv
// fbreader: PLB master that scans the framebuffer in raster order with single-beat reads and
// pushes each pixel, tagged with line/column, into a FIFO. FBR_ERR_CNT_EN adds err_cnt.
module fbreader #(
    parameter int unsigned LINE_LEN     = 9,
    parameter int unsigned COL_LEN      = 10,
    parameter int unsigned NUM_LINES    = 480,
    parameter int unsigned NUM_COLS     = 640,
    parameter logic [0:10] FB_BASE      = 11'b1001_0000_000,
    parameter int unsigned FBR_FIFO_LEN = 64,
    parameter int unsigned C_MST_AWIDTH = 32,
    parameter int unsigned C_MST_DWIDTH = 32
) (
    input  logic                      PLB_clk,
    input  logic                      Bus2IP_Reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [0:FBR_FIFO_LEN-1]   fifo_data,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic                      IP2Bus_MstRd_Req,
    output logic                      IP2Bus_MstWr_Req,
    output logic [0:C_MST_AWIDTH-1]   IP2Bus_Mst_Addr,
    output logic [0:C_MST_DWIDTH/8-1] IP2Bus_Mst_BE,
    output logic                      IP2Bus_Mst_Lock,
    output logic                      IP2Bus_Mst_Reset,
    input  logic                      Bus2IP_Mst_CmdAck,
    input  logic                      Bus2IP_Mst_Cmplt,
    input  logic                      Bus2IP_Mst_Error,
    input  logic                      Bus2IP_Mst_Rearbitrate,
    input  logic                      Bus2IP_Mst_Cmd_Timeout,
    input  logic [0:C_MST_DWIDTH-1]   Bus2IP_MstRd_d,
    input  logic                      Bus2IP_MstRd_src_rdy_n,
    output logic [0:C_MST_DWIDTH-1]   IP2Bus_MstWr_d,
`ifdef FBR_ERR_CNT_EN
    output logic [0:7]                err_cnt,
`endif
    input  logic                      Bus2IP_MstWr_dst_rdy_n
);

    localparam int unsigned PadLen = FBR_FIFO_LEN - LINE_LEN - COL_LEN - C_MST_DWIDTH;
    localparam logic [LINE_LEN-1:0] LastLine = LINE_LEN'(NUM_LINES - 1);
    localparam logic [COL_LEN-1:0]  LastCol  = COL_LEN'(NUM_COLS - 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StPush, StErr} state_e;

    state_e                  state_q, state_d;
    logic [LINE_LEN-1:0]     line_q, line_d;
    logic [COL_LEN-1:0]      col_q, col_d;
    logic [0:C_MST_DWIDTH-1] pixel_q;
    logic                    have_data_q;
    logic                    done_q;
    logic                    mst_reset_q;

    logic bus_err;
    logic in_xfer;
    logic capture;
    logic data_ok;
    logic push;
    logic last_pix;

    assign bus_err  = Bus2IP_Mst_Error | Bus2IP_Mst_Cmd_Timeout;
    assign in_xfer  = (state_q == StReq) || (state_q == StWait);
    assign capture  = in_xfer && !Bus2IP_MstRd_src_rdy_n;
    // Data may arrive before Cmplt or in the same cycle; either counts as captured.
    assign data_ok  = have_data_q || !Bus2IP_MstRd_src_rdy_n;
    assign push     = (state_q == StPush) && !fifo_full;
    assign last_pix = (line_q == LastLine) && (col_q == LastCol);

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    line_d  = '0;
                    col_d   = '0;
                end
            end
            StReq: begin
                if (bus_err) begin
                    state_d = StErr;
                end else if (Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) begin
                    state_d = data_ok ? StPush : StErr;
                end else if (Bus2IP_Mst_CmdAck) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus_err) begin
                    state_d = StErr;
                end else if (Bus2IP_Mst_Cmplt) begin
                    state_d = data_ok ? StPush : StErr;
                end
            end
            StPush: begin
                if (!fifo_full) begin
                    if (last_pix) begin
                        state_d = StIdle;
                        line_d  = '0;
                        col_d   = '0;
                    end else if (col_q == LastCol) begin
                        state_d = StReq;
                        col_d   = '0;
                        line_d  = line_q + LINE_LEN'(1);
                    end else begin
                        state_d = StReq;
                        col_d   = col_q + COL_LEN'(1);
                    end
                end
            end
            StErr: begin
                if (!Bus2IP_Mst_Error) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PLB_clk) begin
        if (Bus2IP_Reset) begin
            state_q     <= StIdle;
            line_q      <= '0;
            col_q       <= '0;
            pixel_q     <= '0;
            have_data_q <= 1'b0;
            done_q      <= 1'b0;
            mst_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            col_q       <= col_d;
            if (capture) begin
                pixel_q <= Bus2IP_MstRd_d;
            end
            // Cleared outside REQ/WAIT so every retry or new pixel needs fresh data.
            have_data_q <= in_xfer && (have_data_q || !Bus2IP_MstRd_src_rdy_n);
            done_q      <= push && last_pix;
            mst_reset_q <= (state_q == StErr);
        end
    end

`ifdef FBR_ERR_CNT_EN
    logic [0:7] err_cnt_q;

    always_ff @(posedge PLB_clk) begin
        if (Bus2IP_Reset) begin
            err_cnt_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            err_cnt_q <= '0;
        end else if ((state_d == StErr) && (state_q != StErr) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign busy             = (state_q != StIdle);
    assign done             = done_q;
    assign fifo_data        = {line_q, col_q, {PadLen{1'b0}}, pixel_q};
    assign fifo_wr_en       = push && !Bus2IP_Reset;
    assign IP2Bus_MstRd_Req = (state_q == StReq) && !Bus2IP_Reset;
    assign IP2Bus_MstWr_Req = 1'b0;
    assign IP2Bus_Mst_Addr  = {FB_BASE, line_q, col_q, 2'b00};
    assign IP2Bus_Mst_BE    = '1;
    assign IP2Bus_Mst_Lock  = 1'b0;
    assign IP2Bus_Mst_Reset = mst_reset_q;
    assign IP2Bus_MstWr_d   = '0;

    logic unused_inputs;
    assign unused_inputs = ^{Bus2IP_Mst_Rearbitrate, Bus2IP_MstWr_dst_rdy_n};

endmodule

// File: tb/tb_fbreader.sv
// Bench for fbreader on a 2x3 frame: randomized IPIF responder and FIFO back-pressure checked
// against a pixel-index model of the raster scan.
module tb_fbreader;

    localparam int unsigned NL   = 2;
    localparam int unsigned NC   = 3;
    localparam int unsigned NPIX = NL * NC;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [10:0] BASE = 11'b1001_0000_000;

    logic        PLB_clk      = 1'b0;
    logic        Bus2IP_Reset = 1'b1;
    logic        start        = 1'b0;
    logic        fifo_full    = 1'b0;
    logic        ack          = 1'b0;
    logic        cmplt        = 1'b0;
    logic        mst_err      = 1'b0;
    logic        tmo          = 1'b0;
    logic        rearb        = 1'b0;
    logic        src_rdy_n    = 1'b1;
    logic        wr_dst_rdy_n = 1'b1;
    logic [0:31] rd_d         = '0;

    logic        busy, done, fifo_wr_en, rd_req, wr_req, mst_lock, mst_reset;
    logic [0:63] fifo_data;
    logic [0:31] mst_addr, wr_d;
    logic [0:3]  mst_be;
`ifdef FBR_ERR_CNT_EN
    logic [0:7]  err_cnt;
`endif

    fbreader #(
        .NUM_LINES (NL),
        .NUM_COLS  (NC)
    ) dut (
        .PLB_clk                (PLB_clk),
        .Bus2IP_Reset           (Bus2IP_Reset),
        .start                  (start),
        .busy                   (busy),
        .done                   (done),
        .fifo_data              (fifo_data),
        .fifo_full              (fifo_full),
        .fifo_wr_en             (fifo_wr_en),
        .IP2Bus_MstRd_Req       (rd_req),
        .IP2Bus_MstWr_Req       (wr_req),
        .IP2Bus_Mst_Addr        (mst_addr),
        .IP2Bus_Mst_BE          (mst_be),
        .IP2Bus_Mst_Lock        (mst_lock),
        .IP2Bus_Mst_Reset       (mst_reset),
        .Bus2IP_Mst_CmdAck      (ack),
        .Bus2IP_Mst_Cmplt       (cmplt),
        .Bus2IP_Mst_Error       (mst_err),
        .Bus2IP_Mst_Rearbitrate (rearb),
        .Bus2IP_Mst_Cmd_Timeout (tmo),
        .Bus2IP_MstRd_d         (rd_d),
        .Bus2IP_MstRd_src_rdy_n (src_rdy_n),
        .IP2Bus_MstWr_d         (wr_d),
`ifdef FBR_ERR_CNT_EN
        .err_cnt                (err_cnt),
`endif
        .Bus2IP_MstWr_dst_rdy_n (wr_dst_rdy_n)
    );

    always #5 PLB_clk = ~PLB_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which pixel is due, what the DUT should be doing this cycle.
    int pix_idx = 0, pushes = 0, done_seen = 0, err_model = 0;
    int resp_wait = 0, err_left = 0;
    bit pending = 0, resp_active = 0, resp_early = 0, in_err = 0, prev_in_err = 0;
    bit prev_rst = 1, exp_busy = 0, exp_done = 0, exp_req = 0, err_done = 0, chain = 0;

    // Stimulus knobs.
    int p_full = 0, p_err = 0, p_same = 0, fixed_wait = 2;
    int stall_pix = -1, stall_len = 0, stall_cnt = 0, err_pix = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int idx);
        logic [8:0] l;
        logic [9:0] c;
        l = 9'(idx / NC);
        c = 10'(idx % NC);
        return {BASE, l, c, 2'b00};
    endfunction

    function automatic logic [63:0] exp_word(input int idx);
        logic [8:0] l;
        logic [9:0] c;
        l = 9'(idx / NC);
        c = 10'(idx % NC);
        return {l, c, 13'd0, exp_addr(idx) ^ KEY};
    endfunction

    function automatic void bump_err();
        if (err_model < 255) err_model++;
    endfunction

    task automatic step(input bit do_start, input bit do_rst);
        bit nxt_in_err, nxt_pending, nxt_req, nxt_busy, nxt_done, wrote;
        int r;
        @(negedge PLB_clk);
        start        = do_start;
        Bus2IP_Reset = do_rst;
        ack = 0; cmplt = 0; mst_err = 0; tmo = 0; src_rdy_n = 1;
        rd_d         = 32'($urandom);
        rearb        = 1'($urandom);
        wr_dst_rdy_n = 1'($urandom);
        if (pending && pix_idx == stall_pix && stall_cnt < stall_len) begin
            fifo_full = 1;
            stall_cnt++;
        end else begin
            fifo_full = ($urandom_range(0, 99) < p_full);
        end
        nxt_in_err = 0; nxt_pending = 0; nxt_req = 0;
        #1;
        if (do_rst) begin
            check("req_in_reset", rd_req, 0);
        end else if (in_err) begin
            check("req_in_err", rd_req, 0);
            if (err_left > 0) begin
                mst_err = 1;
                err_left--;
                nxt_in_err = 1;
            end else begin
                nxt_req = 1;
            end
        end else if (resp_active) begin
            check("req_in_wait", rd_req, 0);
            resp_wait--;
            if (resp_early && resp_wait == 1) begin
                src_rdy_n = 0;
                rd_d = exp_addr(pix_idx) ^ KEY;
            end
            if (resp_wait == 0) begin
                resp_active = 0;
                cmplt = 1;
                r = $urandom_range(0, 99);
                if (r < p_err) begin
                    mst_err = 1;
                    err_left = $urandom_range(0, 1);
                    nxt_in_err = 1;
                    bump_err();
                end else if (r < 2 * p_err && !resp_early) begin
                    nxt_in_err = 1;  // completion without any data beat
                    bump_err();
                end else begin
                    if (!resp_early) begin
                        src_rdy_n = 0;
                        rd_d = exp_addr(pix_idx) ^ KEY;
                    end
                    nxt_pending = 1;
                end
            end
        end else if (rd_req) begin
            check("req_addr", mst_addr, exp_addr(pix_idx));
            ack = 1;
            r = $urandom_range(0, 99);
            if (err_pix == pix_idx && !err_done) begin
                err_done = 1;
                mst_err = 1;
                err_left = 1;
                nxt_in_err = 1;
                bump_err();
            end else if (r < p_err) begin
                if ($urandom_range(0, 2) == 0) begin
                    tmo = 1;
                    err_left = 0;
                end else begin
                    mst_err = 1;
                    err_left = $urandom_range(0, 1);
                end
                if ($urandom_range(0, 1) == 1) begin
                    cmplt = 1;
                    src_rdy_n = 0;
                end
                nxt_in_err = 1;
                bump_err();
            end else if (r < p_err + p_same) begin
                cmplt = 1;
                src_rdy_n = 0;
                rd_d = exp_addr(pix_idx) ^ KEY;
                nxt_pending = 1;
            end else begin
                resp_active = 1;
                resp_wait = (fixed_wait > 0) ? fixed_wait : $urandom_range(1, 3);
                resp_early = (fixed_wait == 0) && (resp_wait > 1) && ($urandom_range(0, 1) == 1);
            end
        end
        #1;
        check("mst_reset", mst_reset, prev_rst || prev_in_err);
        check("done", done, exp_done);
        check("busy", busy, exp_busy);
        if (exp_req && !do_rst) check("req_latency", rd_req, 1);
        wrote = 0;
        if (pending && !do_rst) begin
            check("req_in_push", rd_req, 0);
            check("push_data", fifo_data, exp_word(pix_idx));
            check("wr_en", fifo_wr_en, !fifo_full);
            wrote = fifo_wr_en;
        end else begin
            check("wr_idle", fifo_wr_en, 0);
        end
        if (done === 1'b1) done_seen++;

        nxt_busy = exp_busy;
        nxt_done = 0;
        if (do_rst) begin
            pending = 0; resp_active = 0; err_left = 0; err_model = 0;
            nxt_in_err = 0; nxt_req = 0; nxt_busy = 0;
        end else begin
            if (wrote) begin
                pushes++;
                pix_idx++;
                if (pix_idx == NPIX) begin
                    nxt_busy = 0;
                    nxt_done = 1;
                end else begin
                    nxt_req = 1;
                end
            end
            if (do_start && !exp_busy) begin
                nxt_busy = 1;
                nxt_req = 1;
                pix_idx = 0;
                err_model = 0;
            end
            pending = (pending && !wrote) || nxt_pending;
        end
        prev_rst    = do_rst;
        prev_in_err = in_err;
        in_err      = nxt_in_err;
        exp_busy    = nxt_busy;
        exp_done    = nxt_done;
        exp_req     = nxt_req;
    endtask

    task automatic run_frame(input int bs_pix, input bit chained, input bit chain_next);
        int cyc, ds0;
        bit got, bs_done, do_s;
        stall_cnt = 0;
        err_done = 0;
        ds0 = done_seen;
        got = 0; bs_done = 0; cyc = 0;
        if (!chained) step(1, 0);
        while (!got && cyc < 2000) begin
            do_s = 0;
            if (exp_done) begin
                do_s = chain_next;
                got = 1;
            end else if (exp_busy && !bs_done && pix_idx == bs_pix) begin
                do_s = 1;
                bs_done = 1;
            end
            step(do_s, 0);
            cyc++;
        end
        check("frame_end", got, 1);
        check("done_count", done_seen - ds0, 1);
`ifdef FBR_ERR_CNT_EN
        check("err_cnt", err_cnt, err_model);
`endif
        if (!got) step(0, 1);
    endtask

    task automatic reset_mid_read();
        int cyc, p0;
        p_same = 0; p_err = 0; p_full = 0; fixed_wait = 3;
        cyc = 0;
        step(1, 0);
        while (!resp_active && cyc < 50) begin
            step(0, 0);
            cyc++;
        end
        check("wait_reached", resp_active, 1);
        p0 = pushes;
        step(0, 1);  // first WAIT cycle of the read
        step(0, 0);
        step(0, 0);
        check("no_push_after_reset", pushes - p0, 0);
    endtask

    initial begin
        repeat (3) step(0, 1);
        step(0, 0);
        step(0, 0);
        check("wr_req_tied", wr_req, 0);
        check("lock_tied", mst_lock, 0);
        check("be_ones", mst_be, 4'hF);
        check("wr_d_tied", wr_d, 0);

        // Basic frame: every read acked, completed two cycles later.
        p_full = 0; p_err = 0; p_same = 0; fixed_wait = 2;
        run_frame(-1, 0, 0);
        check("basic_pushes", pushes, NPIX);
        step(0, 0);

        // Back-pressure at pixel (0,1).
        stall_pix = 1; stall_len = 5;
        run_frame(-1, 0, 0);
        stall_pix = -1; stall_len = 0;
        step(0, 0);

        // Ack, complete and data in the same cycle.
        p_same = 100;
        run_frame(-1, 0, 0);
        step(0, 0);

        // Bus error on pixel (1,1), then retry.
        p_same = 0; err_pix = 4;
        run_frame(-1, 0, 0);
        check("err_model_one", err_model, 1);
        err_pix = -1;
        step(0, 0);

        // Reset during a read, then a clean frame from (0,0).
        reset_mid_read();
        fixed_wait = 2;
        run_frame(-1, 0, 0);

        // Start while busy at pixel (0,2); start again on the done cycle.
        run_frame(2, 0, 1);
        chain = 1;

        p_full = 30; p_err = 10; p_same = 30; fixed_wait = 0;
        for (int f = 0; f < 20; f++) begin
            bit nx;
            nx = (f < 19) && ($urandom_range(0, 3) == 0);
            run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NPIX - 1)) : -1,
                      chain, nx);
            chain = nx;
            if (!chain) repeat ($urandom_range(0, 2)) step(0, 0);
        end
        repeat (3) step(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
